huffman_bit_packer: RTL and testbench

- Downstream stage of the Huffman encoder.
- Accepts variable-length codewords (code, length) on a valid/ready stream and packs them MSB-first into fixed-width output words on a second valid/ready stream.
- Handles words that straddle codeword boundaries and end-of-block flush with zero padding.
- Reports the number of valid bits in the final word.

---
 rtl/huffman_bit_packer.sv | 231 +++++++++++++++++++++++
 tb/tb_huffman_bit_packer.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/huffman_bit_packer.sv
// huffman_bit_packer
// Packs variable-length, right-aligned Huffman codewords MSB-first into
// fixed-width output words. A block is terminated by a codeword flagged
// in_last; the tail is flushed zero-padded with its valid-bit count.
//
// Ports:
//   i_clk, i_rst       clock and asynchronous active-high reset
//   i_in_valid/o_in_ready, i_in_code, i_in_len, i_in_last
//                      codeword stream (code right-aligned, bit len-1 first)
//   o_out_valid/i_out_ready, o_out_data, o_out_nbits, o_out_last
//                      packed word stream (first bit at OUT_W-1)
//   o_err_len          sticky: a codeword longer than CODE_W was accepted
//   o_bit_total        bits accepted in the current block (mod 2^32)
module huffman_bit_packer #(
  parameter int CODE_W = 16,
  parameter int OUT_W  = 32,
  parameter int LEN_W  = 5,
  parameter int NB_W   = 6
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [CODE_W-1:0] i_in_code,
  input  logic [LEN_W-1:0]  i_in_len,
  input  logic              i_in_last,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [OUT_W-1:0]  o_out_data,
  output logic [NB_W-1:0]   o_out_nbits,
  output logic              o_out_last,
  output logic              o_err_len,
  output logic [31:0]       o_bit_total
);

  localparam int ACC_W  = OUT_W + CODE_W;
  localparam int FILL_W = $clog2(ACC_W + 1);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_FINAL = 2'd2
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [ACC_W-1:0]  r_acc, w_acc_nxt;
  logic [FILL_W-1:0] r_fill, w_fill_nxt;
  logic              r_out_valid, w_out_valid_nxt;
  logic [OUT_W-1:0]  r_out_data, w_out_data_nxt;
  logic [NB_W-1:0]   r_out_nbits, w_out_nbits_nxt;
  logic              r_out_last, w_out_last_nxt;
  logic              r_err_len, w_err_len_nxt;
  logic [31:0]       r_bit_total, w_bit_total_nxt;

  logic              w_in_fire, w_out_fire, w_len_bad;
  logic [CODE_W-1:0] w_code_mask;
  logic [ACC_W-1:0]  w_code_ext, w_acc_app, w_acc_shl;
  logic [FILL_W-1:0] w_fill_add, w_fill_sub, w_shamt;

  assign o_in_ready  = (r_state == ST_RUN) && (r_fill < FILL_W'(OUT_W));
  assign w_in_fire   = i_in_valid & o_in_ready;
  assign w_out_fire  = r_out_valid & i_out_ready;
  assign w_len_bad   = (i_in_len > LEN_W'(CODE_W));

  // Bits of in_code above in_len are don't-care and must not leak into the stream.
  assign w_code_mask = ~({CODE_W{1'b1}} << i_in_len);
  assign w_code_ext  = {{OUT_W{1'b0}}, i_in_code & w_code_mask};
  assign w_fill_add  = r_fill + FILL_W'(i_in_len);
  // Place the codeword immediately below the current fill bits.
  assign w_shamt     = FILL_W'(ACC_W) - w_fill_add;
  assign w_acc_app   = r_acc | (w_code_ext << w_shamt);
  assign w_acc_shl   = r_acc << OUT_W;
  assign w_fill_sub  = r_fill - FILL_W'(OUT_W);

  // Next accumulator, fill and state.
  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_fill_nxt  = r_fill;
    case (r_state)
      ST_RUN: begin
        if (w_in_fire) begin
          if (!w_len_bad) begin
            w_acc_nxt  = w_acc_app;
            w_fill_nxt = w_fill_add;
          end else begin
            w_acc_nxt  = r_acc;
            w_fill_nxt = r_fill;
          end
          if (i_in_last) begin
            if (w_fill_nxt >= FILL_W'(OUT_W)) begin
              w_state_nxt = ST_DRAIN;
            end else begin
              w_state_nxt = ST_FINAL;
            end
          end else begin
            w_state_nxt = ST_RUN;
          end
        end else if (w_out_fire) begin
          w_acc_nxt  = w_acc_shl;
          w_fill_nxt = w_fill_sub;
        end else begin
          w_acc_nxt  = r_acc;
        end
      end
      ST_DRAIN: begin
        if (w_out_fire) begin
          w_acc_nxt  = w_acc_shl;
          w_fill_nxt = w_fill_sub;
          if (w_fill_sub == {FILL_W{1'b0}}) begin
            w_state_nxt = ST_RUN;
          end else if (w_fill_sub < FILL_W'(OUT_W)) begin
            w_state_nxt = ST_FINAL;
          end else begin
            w_state_nxt = ST_DRAIN;
          end
        end else begin
          w_acc_nxt = r_acc;
        end
      end
      ST_FINAL: begin
        if (w_out_fire) begin
          w_acc_nxt   = {ACC_W{1'b0}};
          w_fill_nxt  = {FILL_W{1'b0}};
          w_state_nxt = ST_RUN;
        end else begin
          w_acc_nxt = r_acc;
        end
      end
      default: begin
        w_acc_nxt   = {ACC_W{1'b0}};
        w_fill_nxt  = {FILL_W{1'b0}};
        w_state_nxt = ST_RUN;
      end
    endcase
  end

  // Output word derived from the next state so it is registered, not combinational.
  always_comb begin
    w_out_valid_nxt = 1'b0;
    w_out_data_nxt  = {OUT_W{1'b0}};
    w_out_nbits_nxt = {NB_W{1'b0}};
    w_out_last_nxt  = 1'b0;
    case (w_state_nxt)
      ST_RUN: begin
        if (w_fill_nxt >= FILL_W'(OUT_W)) begin
          w_out_valid_nxt = 1'b1;
          w_out_data_nxt  = w_acc_nxt[ACC_W-1 -: OUT_W];
          w_out_nbits_nxt = NB_W'(OUT_W);
        end else begin
          w_out_valid_nxt = 1'b0;
        end
      end
      ST_DRAIN: begin
        w_out_valid_nxt = 1'b1;
        w_out_data_nxt  = w_acc_nxt[ACC_W-1 -: OUT_W];
        w_out_nbits_nxt = NB_W'(OUT_W);
        // A drain word that empties the accumulator closes the block.
        w_out_last_nxt  = (w_fill_nxt == FILL_W'(OUT_W));
      end
      ST_FINAL: begin
        // Bits below fill are always zero, so this is already zero-padded.
        w_out_valid_nxt = 1'b1;
        w_out_data_nxt  = w_acc_nxt[ACC_W-1 -: OUT_W];
        w_out_nbits_nxt = NB_W'(w_fill_nxt);
        w_out_last_nxt  = 1'b1;
      end
      default: begin
        w_out_valid_nxt = 1'b0;
      end
    endcase
  end

  // Block bit counter and sticky length error.
  always_comb begin
    w_bit_total_nxt = r_bit_total;
    w_err_len_nxt   = r_err_len;
    if (w_in_fire && !w_len_bad) begin
      w_bit_total_nxt = r_bit_total + 32'(i_in_len);
    end else if (w_out_fire && r_out_last) begin
      w_bit_total_nxt = 32'd0;
    end else begin
      w_bit_total_nxt = r_bit_total;
    end
    if (w_in_fire && w_len_bad) begin
      w_err_len_nxt = 1'b1;
    end else begin
      w_err_len_nxt = r_err_len;
    end
  end

  // Packing state registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_RUN;
      r_acc   <= {ACC_W{1'b0}};
      r_fill  <= {FILL_W{1'b0}};
    end else begin
      r_state <= w_state_nxt;
      r_acc   <= w_acc_nxt;
      r_fill  <= w_fill_nxt;
    end
  end

  // Registered output stream and status.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= {OUT_W{1'b0}};
      r_out_nbits <= {NB_W{1'b0}};
      r_out_last  <= 1'b0;
      r_err_len   <= 1'b0;
      r_bit_total <= 32'd0;
    end else begin
      r_out_valid <= w_out_valid_nxt;
      r_out_data  <= w_out_data_nxt;
      r_out_nbits <= w_out_nbits_nxt;
      r_out_last  <= w_out_last_nxt;
      r_err_len   <= w_err_len_nxt;
      r_bit_total <= w_bit_total_nxt;
    end
  end

  assign o_out_valid = r_out_valid;
  assign o_out_data  = r_out_data;
  assign o_out_nbits = r_out_nbits;
  assign o_out_last  = r_out_last;
  assign o_err_len   = r_err_len;
  assign o_bit_total = r_bit_total;

endmodule

// File: tb/tb_huffman_bit_packer.sv
// Self-checking bench for huffman_bit_packer: table of codewords with the
// words they complete, a scoreboard queue popped by an output monitor, and
// hand-written sequences for backpressure, block totals, errors and reset.
module tb_huffman_bit_packer;

  logic        clk = 1'b0;
  logic        i_rst;
  logic        i_in_valid;
  logic        o_in_ready;
  logic [15:0] i_in_code;
  logic [4:0]  i_in_len;
  logic        i_in_last;
  logic        o_out_valid;
  logic        i_out_ready;
  logic [31:0] o_out_data;
  logic [5:0]  o_out_nbits;
  logic        o_out_last;
  logic        o_err_len;
  logic [31:0] o_bit_total;

  always #5 clk = ~clk;

  huffman_bit_packer dut (
    .i_clk(clk), .i_rst(i_rst),
    .i_in_valid(i_in_valid), .o_in_ready(o_in_ready),
    .i_in_code(i_in_code), .i_in_len(i_in_len), .i_in_last(i_in_last),
    .o_out_valid(o_out_valid), .i_out_ready(i_out_ready),
    .o_out_data(o_out_data), .o_out_nbits(o_out_nbits), .o_out_last(o_out_last),
    .o_err_len(o_err_len), .o_bit_total(o_bit_total)
  );

  typedef struct {
    logic [31:0] data;
    logic [5:0]  nbits;
    logic        last;
  } exp_t;

  typedef struct {
    logic [15:0] code;
    logic [4:0]  len;
    logic        last;
    int          nexp;
    exp_t        e0;
    exp_t        e1;
  } row_t;

  exp_t exp_q[$];
  row_t tbl[22];
  int   checks = 0;
  int   errors = 0;
  int   words_seen = 0;
  int   ready_low = 0;
  bit   count_ready_low = 1'b0;

  function automatic exp_t mkw(input logic [31:0] d, input logic [5:0] n, input logic l);
    exp_t e;
    e.data = d; e.nbits = n; e.last = l;
    return e;
  endfunction

  function automatic row_t mk(input logic [15:0] c, input logic [4:0] l, input logic lst,
                              input int n, input exp_t e0, input exp_t e1);
    row_t r;
    r.code = c; r.len = l; r.last = lst; r.nexp = n; r.e0 = e0; r.e1 = e1;
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, got, req);
    end
  endtask

  // Holds the codeword until it is accepted; leaves in_valid high for back-to-back use.
  task automatic send_cw(input logic [15:0] c, input logic [4:0] l, input logic lst);
    int t;
    i_in_valid = 1'b1; i_in_code = c; i_in_len = l; i_in_last = lst;
    t = 0;
    while (!o_in_ready && t < 100) begin
      step();
      t++;
    end
    if (!o_in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready=0 after %0d cycles, required 1", t);
    end else begin
      step();
    end
  endtask

  task automatic idle();
    i_in_valid = 1'b0; i_in_last = 1'b0; i_in_code = 16'h0000; i_in_len = 5'd0;
  endtask

  task automatic apply_row(input row_t r);
    if (r.nexp >= 1) exp_q.push_back(r.e0);
    if (r.nexp >= 2) exp_q.push_back(r.e1);
    send_cw(r.code, r.len, r.last);
  endtask

  task automatic wait_empty(input string name);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      step();
      t++;
    end
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    exp_t nw;
    int   w0;
    nw = mkw(32'h0, 6'd0, 1'b0);

    // Table: codewords and the words each one completes.
    for (int i = 0; i < 8; i++)
      tbl[i] = mk(16'(i + 1), 5'd4, 1'b0, (i == 7) ? 1 : 0, mkw(32'h12345678, 6'd32, 1'b0), nw);
    tbl[8]  = mk(16'hFFFF, 5'd16, 1'b0, 0, nw, nw);
    tbl[9]  = mk(16'h0001, 5'd16, 1'b1, 1, mkw(32'hFFFF0001, 6'd32, 1'b1), nw);
    tbl[10] = mk(16'h0000, 5'd0,  1'b1, 1, mkw(32'h00000000, 6'd0, 1'b1), nw);
    tbl[11] = mk(16'hFFF3, 5'd2,  1'b0, 0, nw, nw);
    tbl[12] = mk(16'h0000, 5'd3,  1'b0, 0, nw, nw);
    tbl[13] = mk(16'hFFFF, 5'd1,  1'b1, 1, mkw(32'hC4000000, 6'd6, 1'b1), nw);
    for (int i = 14; i < 21; i++)
      tbl[i] = mk(16'h000F, 5'd4, 1'b0, 0, nw, nw);
    tbl[21] = mk(16'h1234, 5'd16, 1'b1, 2, mkw(32'hFFFFFFF1, 6'd32, 1'b0),
                 mkw(32'h23400000, 6'd12, 1'b1));

    i_rst = 1'b1; i_out_ready = 1'b1;
    idle();

    // Output monitor: every accepted word is compared with the scoreboard head.
    fork
      begin : monitor
        exp_t e;
        forever begin
          @(negedge clk);
          if (!i_rst) begin
            if (count_ready_low && !o_in_ready) ready_low++;
            if (o_out_valid && i_out_ready) begin
              words_seen++;
              checks++;
              if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL word_unexpected: got data=%h nbits=%0d last=%0b, required no word",
                         o_out_data, o_out_nbits, o_out_last);
              end else begin
                e = exp_q.pop_front();
                if (o_out_data !== e.data || o_out_nbits !== e.nbits || o_out_last !== e.last) begin
                  errors++;
                  $display("FAIL word_%0d: got data=%h nbits=%0d last=%0b, required data=%h nbits=%0d last=%0b",
                           words_seen, o_out_data, o_out_nbits, o_out_last, e.data, e.nbits, e.last);
                end
              end
            end
          end
        end
      end
    join_none

    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(o_out_valid), 32'd0);
    check("rst_out_data", o_out_data, 32'd0);
    check("rst_out_nbits", 32'(o_out_nbits), 32'd0);
    check("rst_out_last", 32'(o_out_last), 32'd0);
    check("rst_err_len", 32'(o_err_len), 32'd0);
    check("rst_bit_total", o_bit_total, 32'd0);
    i_rst = 1'b0;
    step();
    check("rst_in_ready", 32'(o_in_ready), 32'd1);

    // Eight nibbles: one full word, in_ready low for exactly one cycle.
    ready_low = 0;
    count_ready_low = 1'b1;
    for (int i = 0; i < 8; i++) apply_row(tbl[i]);
    idle();
    repeat (4) step();
    count_ready_low = 1'b0;
    check("ready_low_cycles", 32'(ready_low), 32'd1);

    for (int i = 8; i < 22; i++) apply_row(tbl[i]);
    idle();
    wait_empty("table_drain");

    // Straddle with a zero-length last codeword; bit_total holds until the last word fires.
    exp_q.push_back(mkw(32'hABCDEF12, 6'd32, 1'b0));
    exp_q.push_back(mkw(32'h30000000, 6'd4, 1'b1));
    send_cw(16'h0ABC, 5'd12, 1'b0);
    send_cw(16'h0DEF, 5'd12, 1'b0);
    send_cw(16'h0123, 5'd12, 1'b0);
    send_cw(16'h0000, 5'd0, 1'b1);
    i_out_ready = 1'b0;
    idle();
    step();
    check("straddle_total_pending", o_bit_total, 32'd36);
    check("straddle_last_pending", 32'(o_out_valid & o_out_last), 32'd1);
    i_out_ready = 1'b1;
    step();
    check("straddle_total_cleared", o_bit_total, 32'd0);
    wait_empty("straddle_drain");

    // Backpressure: word held stable for 5 cycles while a further codeword waits.
    i_out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i == 7) exp_q.push_back(mkw(32'h87654321, 6'd32, 1'b0));
      send_cw(16'(8 - i), 5'd4, 1'b0);
    end
    fork
      begin
        exp_q.push_back(mkw(32'hC0000000, 6'd4, 1'b1));
        send_cw(16'h000C, 5'd4, 1'b1);
      end
      begin
        for (int k = 0; k < 5; k++) begin
          check("bp_hold", {o_out_valid, o_in_ready, 30'd0} ^ o_out_data,
                {1'b1, 1'b0, 30'd0} ^ 32'h87654321);
          step();
        end
        w0 = words_seen;
        i_out_ready = 1'b1;
        step();
        check("bp_first_ready_accept", 32'(words_seen - w0), 32'd1);
      end
    join
    idle();
    wait_empty("bp_drain");

    // Illegal length: dropped, sticky error, fill and total untouched.
    check("err_before", 32'(o_err_len), 32'd0);
    exp_q.push_back(mkw(32'h5AA50000, 6'd16, 1'b1));
    send_cw(16'h005A, 5'd8, 1'b0);
    send_cw(16'hFFFF, 5'd17, 1'b0);
    check("err_set", 32'(o_err_len), 32'd1);
    check("err_total_unchanged", o_bit_total, 32'd8);
    send_cw(16'h00A5, 5'd8, 1'b1);
    idle();
    wait_empty("err_drain1");
    exp_q.push_back(mkw(32'hA5000000, 6'd8, 1'b1));
    send_cw(16'hFFFF, 5'd17, 1'b0);
    check("err_total_zero", o_bit_total, 32'd0);
    send_cw(16'h00A5, 5'd8, 1'b1);
    idle();
    wait_empty("err_drain2");
    check("err_sticky", 32'(o_err_len), 32'd1);

    // Reset mid-packing at fill=20: partial bits must not reappear.
    send_cw(16'hFFFF, 5'd16, 1'b0);
    send_cw(16'h000F, 5'd4, 1'b0);
    idle();
    i_rst = 1'b1;
    #1;
    check("midrst_out_valid", 32'(o_out_valid), 32'd0);
    check("midrst_err_len", 32'(o_err_len), 32'd0);
    check("midrst_bit_total", o_bit_total, 32'd0);
    exp_q.delete();
    repeat (2) step();
    i_rst = 1'b0;
    #1;
    check("midrst_in_ready", 32'(o_in_ready), 32'd1);
    exp_q.push_back(mkw(32'h10000000, 6'd4, 1'b1));
    send_cw(16'h0001, 5'd4, 1'b1);
    idle();
    wait_empty("midrst_drain");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
